// File: rtl/cpu_pkg.sv
// Shared encodings and types for the cpu datapath and its register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    // R/I-type field layout; the I-immediate overlays funct7:rs2.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    function automatic logic [XLEN-1:0] sext_imm_i(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 reads zero.
// Latency: reads combinational; a write lands on the next CLK edge (same-cycle read sees old value).
// Backpressure: none; one write accepted every cycle, async clear while RST_X is high.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_X,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rrs1,
    output logic [XLEN-1:0] rrs2,
    input  logic            we,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] x [NREG];

    // Register array: cleared asynchronously, x0 never written.
    always_ff @(posedge CLK or posedge RST_X) begin
        if (RST_X) begin
            for (int i = 0; i < NREG; i++) begin
                x[i] <= '0;
            end
        end else if (we && (rd != 5'd0)) begin
            x[rd] <= wdata;
        end
    end

    assign rrs1 = (rs1 == 5'd0) ? '0 : x[rs1];
    assign rrs2 = (rs2 == 5'd0) ? '0 : x[rs2];

endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I OP/OP-IMM datapath: decode, register read, ALU, writeback.
// Latency: result combinational in the issue cycle, committed on the next CLK edge.
// Backpressure: none; one instruction is accepted and retired every cycle.
module cpu
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] pc,
    input  logic [31:0] instr
);

    instr_t          d;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] rrs1;
    logic [XLEN-1:0] rrs2;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] result;
    logic            we;
    logic            is_op;
    logic            is_opimm;
    alu_op_t         alu_op;
    // The PC only matters to the fetch side in this instruction subset.
    logic            unused_pc;

    assign d         = instr;
    assign rs1       = d.rs1;
    assign rs2       = d.rs2;
    assign rd        = d.rd;
    assign imm_i     = sext_imm_i({d.funct7, d.rs2});
    assign is_op     = (d.opcode == OPC_OP);
    assign is_opimm  = (d.opcode == OPC_OPIMM);
    assign unused_pc = ^pc;

    cpu_regfile regfile (
        .CLK   (CLK),
        .RST_X (RST_X),
        .rs1   (rs1),
        .rs2   (rs2),
        .rrs1  (rrs1),
        .rrs2  (rrs2),
        .we    (we),
        .rd    (rd),
        .wdata (result)
    );

    // Decode: write enable, operand-B source and ALU operation; other opcodes are no-ops.
    always_comb begin
        we     = 1'b0;
        opb    = rrs2;
        alu_op = ALU_NONE;
        if (is_op || is_opimm) begin
            we = 1'b1;
            if (is_opimm) begin
                opb = imm_i;
            end
            case (d.funct3)
                F3_ADD:  alu_op = (is_op && d.funct7[5]) ? ALU_SUB : ALU_ADD;
                F3_SLL:  alu_op = ALU_SLL;
                F3_SLT:  alu_op = ALU_SLT;
                F3_SLTU: alu_op = ALU_SLTU;
                F3_XOR:  alu_op = ALU_XOR;
                F3_SR:   alu_op = d.funct7[5] ? ALU_SRA : ALU_SRL;
                F3_OR:   alu_op = ALU_OR;
                F3_AND:  alu_op = ALU_AND;
                default: alu_op = ALU_NONE;
            endcase
        end
    end

    // ALU: wraps modulo 2^32, shifts use the low five bits of operand B.
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = rrs1 + opb;
            ALU_SUB:  result = rrs1 - opb;
            ALU_SLL:  result = rrs1 << opb[4:0];
            ALU_SLT:  result = {31'b0, ($signed(rrs1) < $signed(opb))};
            ALU_SLTU: result = {31'b0, (rrs1 < opb)};
            ALU_XOR:  result = rrs1 ^ opb;
            ALU_SRL:  result = rrs1 >> opb[4:0];
            ALU_SRA:  result = $unsigned($signed(rrs1) >>> opb[4:0]);
            ALU_OR:   result = rrs1 | opb;
            ALU_AND:  result = rrs1 & opb;
            default:  result = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: an imem model feeds a directed then random program,
// a reference interpreter predicts each cycle's decode/ALU view and the register file.
module tb_cpu;

    logic        CLK   = 1'b0;
    logic        RST_X = 1'b1;
    logic [31:0] pc    = 32'd0;
    logic [31:0] instr;

    // imem: word array indexed by pc[11:2], preloaded below.
    logic [31:0] mem [1024];
    assign instr = mem[pc[11:2]];

    cpu dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .pc    (pc),
        .instr (instr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] rrs1;
        logic [31:0] rrs2;
        logic [31:0] result;
    } exp_t;

    typedef struct {
        int          idx;
        int          r;
        logic [31:0] v;
    } dchk_t;

    exp_t        sb_q[$];
    dchk_t       dchk[$];
    logic [31:0] m_x [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        running  = 1'b0;
    int          prog_len = 0;
    int          rst_idx  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    // Architectural meaning of each funct3; alt is the SUB / arithmetic-shift modifier.
    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0:    return alt ? (a - b) : (a + b);
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> sh) : (a >> sh);
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Interpret one instruction against the model registers and queue the expected view.
    task automatic model_step(input logic [31:0] w);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        int          rd;
        opc = w[6:0];
        f3  = w[14:12];
        rd  = int'(w[11:7]);
        a   = m_x[w[19:15]];
        b   = m_x[w[24:20]];
        imm = {{20{w[31]}}, w[31:20]};
        e.rrs1 = a;
        e.rrs2 = b;
        e.we   = 1'b0;
        e.result = 32'd0;
        if (opc == 7'b0110011) begin
            e.we = 1'b1;
            e.result = alu_ref(f3, w[30], a, b);
        end else if (opc == 7'b0010011) begin
            e.we = 1'b1;
            e.result = alu_ref(f3, (f3 == 3'd5) && w[30], a, imm);
        end
        sb_q.push_back(e);
        if (e.we && rd != 0) m_x[rd] = e.result;
    endtask

    task automatic check_regs(input int tag);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("x%0d@%0d", i, tag), dut.regfile.x[i], m_x[i]);
        end
    endtask

    function automatic logic [31:0] gen_rand();
        logic [31:0] w;
        logic [31:0] r;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  others [7];
        int          sel;
        others = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                   7'b0010111, 7'b1101111, 7'b1110011};
        sel = $urandom_range(0, 9);
        r   = $urandom;
        f3  = r[2:0];
        f7  = r[3] ? 7'h20 : 7'h00;
        imm = r[31:20];
        if (sel < 4) begin
            w = enc_r(f7, $urandom_range(0, 15), $urandom_range(0, 15), f3, $urandom_range(0, 15));
        end else if (sel < 8) begin
            if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
            w = enc_i(imm, $urandom_range(0, 15), f3, $urandom_range(0, 15));
        end else begin
            w = $urandom;
            w[6:0] = others[$urandom_range(0, 6)];
            if (r[4]) w = 32'd0;
        end
        return w;
    endfunction

    task automatic add_dchk(input int idx, input int r, input logic [31:0] v);
        dchk_t c;
        c.idx = idx;
        c.r   = r;
        c.v   = v;
        dchk.push_back(c);
    endtask

    // Monitor: compare the DUT's decode/ALU view each cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (running && !RST_X) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got empty queue expected one entry");
                end else begin
                    e = sb_q.pop_front();
                    check("we", {31'b0, dut.we}, {31'b0, e.we});
                    check("rrs1", dut.rrs1, e.rrs1);
                    check("rrs2", dut.rrs2, e.rrs2);
                    check("result", dut.result, e.result);
                end
            end
        end
    end

    // Driver: preload imem, run reset, then present one instruction per clock.
    initial begin
        int p;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        p = 0;
        mem[p++] = 32'h0000_0000;
        mem[p++] = enc_i(12'd10, 0, 3'd0, 5);             // addi x5,x0,10
        mem[p++] = enc_i(12'd32, 0, 3'd0, 6);             // addi x6,x0,32
        mem[p++] = enc_r(7'h00, 6, 5, 3'd0, 7);           // add x7,x5,x6
        mem[p++] = enc_i(12'd5, 0, 3'd0, 0);              // addi x0,x0,5
        mem[p++] = enc_r(7'h20, 6, 5, 3'd0, 8);           // sub x8,x5,x6
        mem[p++] = enc_r(7'h00, 6, 5, 3'd2, 11);          // slt x11,x5,x6
        mem[p++] = enc_r(7'h00, 5, 6, 3'd3, 9);           // sltu x9,x6,x5
        mem[p++] = enc_i(12'd1, 0, 3'd0, 5);              // addi x5,x0,1
        mem[p++] = enc_i(12'd31, 5, 3'd1, 5);             // slli x5,x5,31
        mem[p++] = enc_i(12'h404, 5, 3'd5, 10);           // srai x10,x5,4
        mem[p++] = enc_i(12'h004, 5, 3'd5, 12);           // srli x12,x5,4
        mem[p++] = enc_i(12'd10, 0, 3'd0, 5);             // addi x5,x0,10
        mem[p++] = enc_i(12'd32, 0, 3'd0, 6);             // addi x6,x0,32
        rst_idx  = p;
        mem[p++] = enc_r(7'h00, 6, 5, 3'd0, 7);           // add x7 (reset hits this cycle)
        mem[p++] = enc_r(7'h00, 6, 5, 3'd0, 7);           // add x7 after reset: 0+0
        while (p < 420) mem[p++] = gen_rand();
        prog_len = p;

        add_dchk(1, 5, 32'd10);
        add_dchk(2, 6, 32'd32);
        add_dchk(3, 7, 32'd42);
        add_dchk(4, 0, 32'd0);
        add_dchk(5, 8, 32'hFFFF_FFEA);
        add_dchk(6, 11, 32'd1);
        add_dchk(7, 9, 32'd0);
        add_dchk(9, 5, 32'h8000_0000);
        add_dchk(10, 10, 32'hF800_0000);
        add_dchk(11, 12, 32'h0800_0000);
        add_dchk(14, 7, 32'd0);
        add_dchk(15, 7, 32'd0);

        RST_X = 1'b1;
        pc    = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check_regs(-1);
        RST_X   = 1'b0;
        running = 1'b1;

        for (int k = 0; k < prog_len; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #1;
                RST_X = 1'b0;
            end
            check_regs(k);
            foreach (dchk[j]) begin
                if (dchk[j].idx == k - 1)
                    check($sformatf("dir_x%0d@%0d", dchk[j].r, dchk[j].idx),
                          dut.regfile.x[dchk[j].r], dchk[j].v);
            end
            pc = 32'(k * 4);
            if (k == rst_idx) begin
                #1;
                RST_X = 1'b1;
                for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
            end else begin
                model_step(mem[k]);
            end
        end

        @(posedge CLK);
        #1;
        running = 1'b0;
        check_regs(prog_len);
        repeat (2) @(posedge CLK);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Single-cycle RV32I integer core datapath covering the OP and OP-IMM instruction classes.
- The PC is owned by the enclosing processor, which advances it by 4 every clock. cpu receives the PC and the fetched instruction word, decodes it, reads the register file, computes the ALU result and writes it back on the next rising clock edge.
- It sits beside the instruction memory (imem) inside the processor wrapper.

Parameters:
- none. The datapath is fixed at 32 bits with 32 architectural registers.

Ports:
- CLK    input  1   system clock; all state updates on the rising edge
- RST_X  input  1   asynchronous, active-high reset
- pc     input  32  address of the current instruction; not used for arithmetic in this subset
- instr  input  32  current instruction word, combinational from imem

Behaviour:
- Decode, all combinational from instr:
  - opcode = instr[6:0], rd = instr[11:7], funct3 = instr[14:12], rs1 = instr[19:15], rs2 = instr[24:20], funct7 = instr[31:25].
  - I-immediate = sign-extend(instr[31:20]).
- Register file: 32 x 32-bit array named x.
  - Two combinational read ports give rrs1 = x[rs1] and rrs2 = x[rs2].
  - x[0] always reads 0.
  - One write port, written on the rising CLK edge when we = 1 and rd != 0.
- we = 1 only for opcode 0110011 (OP) and 0010011 (OP-IMM). Every other opcode, including the all-zero word, gives we = 0 and result = 0, with no architectural effect.
- ALU operand B is rrs2 for OP and the I-immediate for OP-IMM. funct3 selects the operation:
  - 000: ADD. For OP only, funct7[5] = 1 selects SUB. ADDI never subtracts.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU (unsigned).
  - 100: XOR.
  - 101: SRL, or SRA when instr[30] = 1 (applies to both OP and OP-IMM).
  - 110: OR.
  - 111: AND.
- Shift amount is B[4:0]. Arithmetic wraps modulo 2^32. SLT and SLTU produce 0 or 1, zero-extended.
- Latency and hazards:
  - result is combinational within the cycle the instruction is presented; it becomes architecturally visible after the following rising edge.
  - A read in the same cycle as a write to the same register returns the old value. No bypass is needed, because each instruction completes in one cycle.
- Reset:
  - While RST_X = 1, all x[i] are forced to 0 asynchronously and no writes occur.
  - Reset asserted mid-stream discards the write pending for that edge.
  - After release, the first rising edge commits the instruction currently presented.
- Internal nets named we, rs1, rs2, rd, rrs1, rrs2, result and instance regfile (array x) are kept at these names so debug probes can reach them hierarchically.

Decomposition:
- Shared package holds:
  - opcode constants OPC_OP = 7'b0110011 and OPC_OPIMM = 7'b0010011;
  - funct3 encodings (F3_ADD … F3_AND);
  - the ALU operation enum.
- Sub-module regfile: 2 read ports, 1 write port, x0 hard-wired to zero, asynchronous clear. Instantiate it as regfile.
- The ALU stays inline.
- The sibling block imem (not part of cpu):
  - word array mem[0..1023];
  - instr = mem[pc[11:2]], combinational;
  - contents preloaded by the bench.

Test Plan:
- Reset held high, then released -> all x[i] = 0; with instr = 0x00000000, we = 0 and no register changes.
- Sequence: 0x00000000, then addi x5,x0,10, then addi x6,x0,32, then add x7,x5,x6 (rs1 = 5, rs2 = 6), one instruction per clock -> x5 = 10, x6 = 32, then x7 = 42; during the add cycle rrs1 = 10, rrs2 = 32, result = 42.
- addi x0,x0,5 -> we = 1 but x0 still reads 0.
- Set x5 = 10, x6 = 32, then sub x8,x5,x6 -> x8 = 0xFFFFFFEA; slt gives 1; sltu x9,x6,x5 gives 0.
- Set x5 = 0x80000000, then srai x10,x5,4 -> 0xF8000000; srli x10,x5,4 -> 0x08000000; slli x5 by 31 from 1 -> 0x80000000.
- Assert reset for one cycle mid-sequence, in the cycle of an add writing x7 -> x7 stays 0 and all registers are cleared.
